// File: rtl/switch_word_input_pkg.sv
// switch_word_input_pkg: shared state encodings and default debounce length
package switch_word_input_pkg;
   typedef enum logic [1:0] {
      SWI_WAIT_LO = 2'd0,
      SWI_WAIT_HI = 2'd1,
      SWI_FULL    = 2'd2
   } swi_state_t;
   localparam int SWI_DEB_CYCLES = 200;
endpackage

// File: rtl/switch_word_input_btn_debounce.sv
// btn_debounce_001: 2-flop synchroniser, stability counter and one-cycle press pulse
module btn_debounce_001 #(
   parameter int DEB_CYCLES = 200,
   parameter int DEB_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   logic [1:0] sync;
   logic level;
   logic [DEB_W-1:0] cnt;
   // accept a level change only after DEB_CYCLES stable cycles; pulse on the accepted rise
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync <= '0;
         level <= 1'b0;
         cnt <= '0;
         press <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         press <= 1'b0;
         if (sync[1] != level) begin
            if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
               level <= ~level;
               cnt <= '0;
               press <= ~level;
            end else begin
               cnt <= cnt + DEB_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/switch_word_input.sv
// switch_word_input: two debounced presses build a 16-bit word from slide switches; optional ECHO preview under SWI_PARTIAL_ECHO_EN
module switch_word_input
   import switch_word_input_pkg::*;
#(
   parameter int DEB_CYCLES = SWI_DEB_CYCLES,
   parameter int DEB_W = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  SW,
   input  logic        BTN,
   input  logic        RD,
   output logic [15:0] DOUT,
   output logic        VALID,
   output logic        HI_PEND,
   output logic        OVR
`ifdef SWI_PARTIAL_ECHO_EN
   ,
   output logic [15:0] ECHO
`endif
);
   swi_state_t state;
   logic [7:0] sw_meta, sw_sync;
   logic press;
   btn_debounce_001 #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
      .clk(CLK),
      .rst(RST),
      .btn(BTN),
      .press(press)
   );
   // two-flop synchroniser for the switch bank
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= SW;
         sw_sync <= sw_meta;
      end
   end
   // word assembly: low byte, high byte, then hold until read; a read beats a coincident press
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= SWI_WAIT_LO;
         DOUT <= '0;
         VALID <= 1'b0;
         HI_PEND <= 1'b0;
         OVR <= 1'b0;
      end else begin
         case (state)
            SWI_WAIT_LO: if (press) begin
               DOUT[7:0] <= sw_sync;
               HI_PEND <= 1'b1;
               state <= SWI_WAIT_HI;
            end
            SWI_WAIT_HI: if (press) begin
               DOUT[15:8] <= sw_sync;
               HI_PEND <= 1'b0;
               VALID <= 1'b1;
               state <= SWI_FULL;
            end
            SWI_FULL: if (RD) begin
               VALID <= 1'b0;
               OVR <= 1'b0;
               if (press) begin
                  DOUT[7:0] <= sw_sync;
                  HI_PEND <= 1'b1;
                  state <= SWI_WAIT_HI;
               end else begin
                  state <= SWI_WAIT_LO;
               end
            end else if (press) begin
               OVR <= 1'b1;
            end
            default: state <= SWI_WAIT_LO;
         endcase
      end
   end
`ifdef SWI_PARTIAL_ECHO_EN
   // preview of the word as it is being built
   always_ff @(posedge CLK) begin
      if (!RST) ECHO <= '0;
      else ECHO <= state == SWI_FULL ? DOUT :
                   state == SWI_WAIT_HI ? {sw_sync, DOUT[7:0]} : {8'h00, sw_sync};
   end
`endif
endmodule

// File: tb/tb_switch_word_input.sv
// tb_switch_word_input: scoreboard bench for switch_word_input with DEB_CYCLES=4
module tb_switch_word_input;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  SW = '0;
   logic        BTN = 1'b0;
   logic        RD = 1'b0;
   logic [15:0] DOUT;
   logic        VALID, HI_PEND, OVR;
`ifdef SWI_PARTIAL_ECHO_EN
   logic [15:0] echo;
`endif
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   switch_word_input #(.DEB_CYCLES(4), .DEB_W(8)) dut (
      .CLK(CLK),
      .RST(RST),
      .SW(SW),
      .BTN(BTN),
      .RD(RD),
      .DOUT(DOUT),
      .VALID(VALID),
      .HI_PEND(HI_PEND),
      .OVR(OVR)
`ifdef SWI_PARTIAL_ECHO_EN
      ,
      .ECHO(echo)
`endif
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask
   // hold the button until the capture lands, then release until it is debounced low again
   task automatic press_btn(input logic [7:0] val);
      SW = val;
      BTN = 1'b1;
      tick(7);
      BTN = 1'b0;
      tick(7);
   endtask
   task automatic pulse_rd();
      RD = 1'b1;
      tick(1);
      RD = 1'b0;
   endtask
   task automatic pop_word();
      int n = 0;
      while (!VALID && n < 20) begin
         tick(1);
         n++;
      end
      if (!VALID) check("valid_timeout", 16'(VALID), 16'd1);
      else if (exp_q.size() == 0) check("queue_empty", 16'd0, 16'd1);
      else check("word", DOUT, exp_q.pop_front());
   endtask
   initial begin
      SW = 8'h34;
      BTN = 1'b1;
      tick(3);
      check("rst_dout", DOUT, 16'h0000);
      check("rst_valid", 16'(VALID), 16'd0);
      check("rst_hipend", 16'(HI_PEND), 16'd0);
      check("rst_ovr", 16'(OVR), 16'd0);
      RST = 1'b1;
      tick(6);
      check("no_early_press", 16'(HI_PEND), 16'd0);
      tick(1);
      check("lo_hipend", 16'(HI_PEND), 16'd1);
      check("lo_byte", {8'h00, DOUT[7:0]}, 16'h0034);
      BTN = 1'b0;
      tick(7);
      pulse_rd();
      check("rd_ignored_hi", 16'(HI_PEND), 16'd1);
      exp_q.push_back(16'h1234);
      press_btn(8'h12);
      pop_word();
      check("full_hipend", 16'(HI_PEND), 16'd0);
      press_btn(8'hFF);
      check("ovr_set", 16'(OVR), 16'd1);
      check("ovr_dout", DOUT, 16'h1234);
      check("ovr_valid", 16'(VALID), 16'd1);
      pulse_rd();
      check("rd_valid", 16'(VALID), 16'd0);
      check("rd_ovr", 16'(OVR), 16'd0);
      check("rd_hipend", 16'(HI_PEND), 16'd0);
      check("rd_dout_kept", DOUT, 16'h1234);
      SW = 8'h99;
      BTN = 1'b1;
      tick(1);
      BTN = 1'b0;
      tick(1);
      BTN = 1'b1;
      tick(1);
      BTN = 1'b0;
      tick(1);
      check("bounce_none", 16'(HI_PEND), 16'd0);
      BTN = 1'b1;
      tick(6);
      check("bounce_early", 16'(HI_PEND), 16'd0);
      tick(1);
      check("bounce_one", 16'(HI_PEND), 16'd1);
      check("bounce_lo", {8'h00, DOUT[7:0]}, 16'h0099);
      BTN = 1'b0;
      tick(7);
      check("bounce_still_hi", 16'(HI_PEND), 16'd1);
      exp_q.push_back(16'h7899);
      press_btn(8'h78);
      pop_word();
      press_btn(8'hFF);
      check("ovr2_set", 16'(OVR), 16'd1);
      SW = 8'hAB;
      BTN = 1'b1;
      tick(6);
      RD = 1'b1;
      tick(1);
      RD = 1'b0;
      check("sim_valid", 16'(VALID), 16'd0);
      check("sim_ovr", 16'(OVR), 16'd0);
      check("sim_hipend", 16'(HI_PEND), 16'd1);
      check("sim_dout", DOUT, 16'h78AB);
      BTN = 1'b0;
      tick(7);
      exp_q.push_back(16'hCDAB);
      press_btn(8'hCD);
      pop_word();
      pulse_rd();
      press_btn(8'h11);
      check("mid_hipend", 16'(HI_PEND), 16'd1);
      RST = 1'b0;
      tick(1);
      RST = 1'b1;
      check("mid_rst_hipend", 16'(HI_PEND), 16'd0);
      check("mid_rst_dout", DOUT, 16'h0000);
      pulse_rd();
      check("rd_ignored_lo", 16'(VALID), 16'd0);
      press_btn(8'h22);
      check("relo_hipend", 16'(HI_PEND), 16'd1);
      check("relo_dout", DOUT, 16'h0022);
      exp_q.push_back(16'h3322);
      press_btn(8'h33);
      pop_word();
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/switch_word_input.md
Name: switch_word_input

Overview:
- Input-side counterpart of the 7-segment display path: turns the 8 slide switches plus a "load" pushbutton into 16-bit words for the CPU or memory.
- Two debounced presses assemble one word: the first press captures the low byte, the second press captures the high byte.
- The finished word is held with a valid/read handshake until consumed.
- Runs in the 10 kHz CPU clock domain, next to the memory and display blocks.

Parameters:
DEB_CYCLES, 200, consecutive stable cycles before a button level change is accepted (20 ms at 10 kHz)
DEB_W, 8, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES

Ports:
CLK  input  1  system clock (10 kHz divided clock)
RST  input  1  synchronous reset, active-low
SW  input  8  raw slide-switch data, asynchronous
BTN  input  1  raw load pushbutton, asynchronous, active-high
RD  input  1  consumer read strobe, one cycle; honoured only while VALID=1
DOUT  output  16  assembled word, {high byte, low byte}
VALID  output  1  DOUT holds a complete unread word
HI_PEND  output  1  low byte captured, waiting for the high-byte press
OVR  output  1  sticky overrun flag: a press arrived while a word was unread

Behaviour:
- Reset: when RST=0 at a CLK edge, DOUT=16'h0000, VALID=0, HI_PEND=0, OVR=0, state=WAIT_LO, debounce counter=0, debounced level=0, sync flops=0.
  - Reset overrides everything, including in mid-debounce or mid-word. A partially assembled word is discarded.
- Synchronisers:
  - SW and BTN each pass through 2 flops.
  - Synchronised SW is the value captured.
- Debounce:
  - If the synchronised BTN differs from the debounced level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEB_CYCLES-1, the debounced level toggles and the counter clears.
  - Any bounce back before that point restarts the count.
  - A press event is a one-cycle pulse on the 0->1 transition of the debounced level. Releases generate no event.
  - Latency from a clean BTN rise to the press event: 2 + DEB_CYCLES cycles.
- State machine (WAIT_LO, WAIT_HI, FULL):
  - WAIT_LO + press: DOUT[7:0] <= SW_sync; go to WAIT_HI; HI_PEND=1.
  - WAIT_HI + press: DOUT[15:8] <= SW_sync; go to FULL; HI_PEND=0; VALID=1 on the next cycle.
  - FULL + RD (no press): VALID=0; OVR=0; go to WAIT_LO. DOUT keeps its old value until the next capture.
  - FULL + press (no RD): DOUT is unchanged; OVR=1 (sticky); stay in FULL.
  - FULL + RD + press in the same cycle: the read wins; VALID=0; OVR=0; DOUT[7:0] <= SW_sync; go to WAIT_HI.
  - RD in WAIT_LO or WAIT_HI: ignored.
- Outputs are registered, with no combinational path from any input to any output.
- DOUT is stable for the whole time VALID=1.

Optional Feature:
SWI_PARTIAL_ECHO_EN
- Defined:
  - Adds output ECHO[15:0], registered, for a display preview.
  - In WAIT_LO, ECHO = {8'h00, SW_sync}.
  - In WAIT_HI, ECHO = {SW_sync, DOUT[7:0]}.
  - In FULL, ECHO = DOUT.
  - Reset value is 16'h0000.
- Undefined: the ECHO port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encodings (SWI_WAIT_LO=2'd0, SWI_WAIT_HI=2'd1, SWI_FULL=2'd2) and the default DEB_CYCLES constant.
- One sub-module, btn_debounce_001: 2-flop synchroniser, counter and press-pulse output, parameterised by DEB_CYCLES and DEB_W.
- Tests override DEB_CYCLES to 4 for speed.

Test Plan (DEB_CYCLES=4):
- Reset: hold RST=0 for 3 cycles with BTN=1 -> DOUT=0000, VALID=0, HI_PEND=0, OVR=0; no press event until BTN is held for 6 cycles after release of RST.
- Word assembly: SW=8'h34 with a clean press, then SW=8'h12 with a press -> HI_PEND=1 after the first press; VALID=1 and DOUT=16'h1234 after the second; HI_PEND=0.
- Bounce: BTN toggles 1,0,1,0 on alternate cycles, then stays 1 -> exactly one press event, 6 cycles after the final rise; no capture during bouncing.
- Overrun: in FULL with 16'h1234, press with SW=8'hFF -> OVR=1, DOUT stays 1234; then RD -> VALID=0, OVR=0, state WAIT_LO.
- Simultaneous: in FULL, RD coincides with a press event with SW=8'hAB -> VALID=0, OVR=0, DOUT[7:0]=AB, HI_PEND=1.
- Reset mid-word: after the low byte is captured, RST=0 for 1 cycle -> HI_PEND=0, DOUT=0000; the next press captures the low byte again.
